// File: rtl/mem_data_sized_pkg.sv
// rtl/mem_data_sized_pkg.sv - shared size/state encodings and lane helpers
package mem_data_sized_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_RSVD = 2'b11
   } size_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   // Reserved size is treated as misaligned so it can never touch memory.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SIZE_BYTE: is_misaligned = 1'b0;
         SIZE_HALF: is_misaligned = lane[0];
         SIZE_WORD: is_misaligned = (lane != 2'b00);
         default:   is_misaligned = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SIZE_BYTE: lane_enables = 4'b0001 << lane;
         SIZE_HALF: lane_enables = lane[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: lane_enables = 4'b1111;
         default:   lane_enables = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_formatter.sv
// rtl/mem_load_formatter.sv - extracts and extends a byte/half/word from a memory word
module mem_load_formatter
   import mem_data_sized_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] value
);

   logic [7:0]  byte_val;
   logic [15:0] half_val;

   // Select the addressed lane(s) little-endian and apply zero/sign extension.
   always_comb begin
      byte_val = word[{lane, 3'b000} +: 8];
      half_val = lane[1] ? word[31:16] : word[15:0];
      case (size)
         SIZE_BYTE: value = is_unsigned ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
         SIZE_HALF: value = is_unsigned ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
         SIZE_WORD: value = word;
         default:   value = 32'b0;
      endcase
   end

endmodule

// File: rtl/mem_data_sized.sv
// rtl/mem_data_sized.sv - byte-addressed data memory with sized loads/stores and clear sweep
module mem_data_sized
   import mem_data_sized_pkg::*;
#(
   parameter int MEMORY_DEPTH = 32,
   parameter int ADDR_SIZE    = 7,
   parameter int DATA_SIZE    = 32
)(
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic                 i_write,
   input  logic                 i_read,
   input  logic [1:0]           i_size,
   input  logic                 i_unsigned,
   input  logic [ADDR_SIZE-1:0] i_addr,
   input  logic [DATA_SIZE-1:0] i_write_data,
   input  logic                 i_clear,
   input  logic [ADDR_SIZE-3:0] i_debug_addr,
   output logic [DATA_SIZE-1:0] o_read_data,
   output logic [DATA_SIZE-1:0] o_debug_data,
   output logic                 o_misaligned,
   output logic                 o_busy
);

   localparam int IW = ADDR_SIZE - 2;
   localparam logic [IW-1:0] LAST_IDX = IW'(MEMORY_DEPTH - 1);

   logic [DATA_SIZE-1:0] mem [MEMORY_DEPTH];

   state_e               state;
   logic [IW-1:0]        clr_idx;
   logic [IW-1:0]        word_idx;
   logic [1:0]           lane;
   logic                 idle;
   logic                 mis;
   logic                 access;
   logic [3:0]           we;
   logic [IW-1:0]        w_idx;
   logic [DATA_SIZE-1:0] w_data;
   logic [DATA_SIZE-1:0] load_val;

   assign word_idx = i_addr[ADDR_SIZE-1:2];
   assign lane     = i_addr[1:0];

   // Write port mux: the clear sweep owns the port while busy, otherwise sized stores.
   always_comb begin
      idle   = (state == ST_IDLE);
      mis    = is_misaligned(i_size, lane);
      access = idle & i_enable & (i_read | i_write);
      we     = 4'b0000;
      w_idx  = word_idx;
      case (i_size)
         SIZE_BYTE: w_data = {4{i_write_data[7:0]}};
         SIZE_HALF: w_data = {2{i_write_data[15:0]}};
         default:   w_data = i_write_data;
      endcase
      if (!idle) begin
         we     = 4'b1111;
         w_idx  = clr_idx;
         w_data = '0;
      end else if (i_enable && i_write && !mis) begin
         we = lane_enables(i_size, lane);
      end
   end

   mem_load_formatter u_fmt (
      .word        (mem[word_idx]),
      .lane        (lane),
      .size        (i_size),
      .is_unsigned (i_unsigned),
      .value       (load_val)
   );

   // Storage with per-byte enables; no reset so contents survive i_reset.
   always_ff @(posedge i_clock) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
      end
   end

   // Clear-sweep FSM: one word per cycle from index 0 up to the last word.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state   <= ST_IDLE;
         clr_idx <= '0;
         o_busy  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_clear) begin
                  state   <= ST_CLEAR;
                  clr_idx <= '0;
                  o_busy  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (clr_idx == LAST_IDX) begin
                  state   <= ST_IDLE;
                  clr_idx <= '0;
                  o_busy  <= 1'b0;
               end else begin
                  clr_idx <= clr_idx + 1'b1;
               end
            end
            default: begin
               state  <= ST_IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

   // Load result and misalignment flag; reads see the pre-store word (read-first).
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         o_read_data  <= '0;
         o_misaligned <= 1'b0;
      end else if (!idle) begin
         o_read_data  <= '0;
         o_misaligned <= 1'b0;
      end else if (i_enable) begin
         o_misaligned <= access & mis;
         o_read_data  <= (i_read && !mis) ? load_val : '0;
      end else begin
         o_misaligned <= 1'b0;
      end
   end

   // Debug port samples the addressed word every cycle, independent of enable and sweep.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) o_debug_data <= '0;
      else          o_debug_data <= mem[i_debug_addr];
   end

endmodule
